// File: rtl/pick_ddf_ms_n.sv
// pick_ddf_ms_n - multi-stream PICK actor with integrated input buffering.
//
// Each of PORTS data inputs writes tagged words into one FIFO per
// (port, flux) pair. One selector input writes port indices into one FIFO
// per flux. A round-robin arbiter over fluxes forwards at most one selected
// token per cycle to a single tagged output.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_wr      per-port write strobe
//   in_flux    per-port flux tag, port p at [p*FW +: FW]
//   in_data    per-port data, port p at [p*WIDTH +: WIDTH]
//   in_full    full flag of FIFO (p,f) at bit p*FLUX+f
//   sel_wr     selector write strobe
//   sel_flux   selector flux tag
//   sel_data   selector value (port index)
//   sel_full   selector FIFO full, one bit per flux
//   out_wr     output write strobe
//   out_flux   flux tag of the output token (held when idle)
//   out_data   output data (held when idle)
//   out_full   downstream full
//   badsel_cnt saturating count of bad-selector pops (only with macro)
//
// Optional feature macro: PICK_BADSEL_CNT_EN adds the badsel_cnt port.
module pick_ddf_ms_n #(
    parameter  int WIDTH = 8,
    parameter  int PORTS = 2,
    parameter  int FLUX  = 2,
    parameter  int DEPTH = 4,
    localparam int SELW  = ($clog2(PORTS) > 1) ? $clog2(PORTS) : 1,
    localparam int FW    = ($clog2(FLUX)  > 1) ? $clog2(FLUX)  : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PORTS-1:0]       in_wr,
    input  logic [PORTS*FW-1:0]    in_flux,
    input  logic [PORTS*WIDTH-1:0] in_data,
    output logic [PORTS*FLUX-1:0]  in_full,
    input  logic                   sel_wr,
    input  logic [FW-1:0]          sel_flux,
    input  logic [SELW-1:0]        sel_data,
    output logic [FLUX-1:0]        sel_full,
    output logic                   out_wr,
    output logic [FW-1:0]          out_flux,
    output logic [WIDTH-1:0]       out_data,
`ifdef PICK_BADSEL_CNT_EN
    output logic [7:0]             badsel_cnt,
`endif
    input  logic                   out_full
);

    localparam int NQ = PORTS * FLUX;
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    // Data FIFOs, indexed q = p*FLUX + f
    logic [WIDTH-1:0] r_dmem [NQ][DEPTH];
    logic [AW-1:0]    r_dwp  [NQ];
    logic [AW-1:0]    r_drp  [NQ];
    logic [AW:0]      r_dcnt [NQ];

    // Selector FIFOs, one per flux
    logic [SELW-1:0]  r_smem [FLUX][DEPTH];
    logic [AW-1:0]    r_swp  [FLUX];
    logic [AW-1:0]    r_srp  [FLUX];
    logic [AW:0]      r_scnt [FLUX];

    logic [FW-1:0]    r_rr;
    logic [WIDTH-1:0] r_last_data;
    logic [FW-1:0]    r_last_flux;

    logic [NQ-1:0]    w_dfull, w_dwr, w_drd;
    logic [FLUX-1:0]  w_sfull, w_swr, w_srd;
    logic [SELW-1:0]  w_shead [FLUX];
    logic [FLUX-1:0]  w_bad, w_cand;
    logic             w_gnt_any, w_gnt_valid;
    logic [FW-1:0]    w_gnt, w_rr_next;
    logic [WIDTH-1:0] w_sel_data;

    // Full flags come straight from the registered counts.
    always_comb begin
        w_dfull = '0;
        w_sfull = '0;
        for (int unsigned q = 0; q < NQ; q++)
            w_dfull[q] = (r_dcnt[q] == CNT_FULL);
        for (int unsigned f = 0; f < FLUX; f++)
            w_sfull[f] = (r_scnt[f] == CNT_FULL);
    end

    // Write decode: a tag matching no flux selects no FIFO, so it is dropped.
    always_comb begin
        w_dwr = '0;
        w_swr = '0;
        for (int unsigned p = 0; p < PORTS; p++)
            for (int unsigned f = 0; f < FLUX; f++)
                if (in_wr[p] && (in_flux[p*FW +: FW] == FW'(f)) && !w_dfull[p*FLUX + f])
                    w_dwr[p*FLUX + f] = 1'b1;
        for (int unsigned f = 0; f < FLUX; f++)
            if (sel_wr && (sel_flux == FW'(f)) && !w_sfull[f])
                w_swr[f] = 1'b1;
    end

    // Per-flux candidacy. A head selector matching no port is "bad"; bad
    // heads are candidates regardless of out_full, good ones need data and
    // a free downstream.
    always_comb begin
        w_shead = '{default: '0};
        w_bad   = '0;
        w_cand  = '0;
        for (int unsigned f = 0; f < FLUX; f++) begin
            w_shead[f] = r_smem[f][r_srp[f]];
            w_bad[f]   = (r_scnt[f] != '0);
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (w_shead[f] == SELW'(p)) begin
                    w_bad[f]  = 1'b0;
                    w_cand[f] = (r_scnt[f] != '0) && (r_dcnt[p*FLUX + f] != '0) && !out_full;
                end
            end
            if (w_bad[f])
                w_cand[f] = 1'b1;
        end
    end

    // Round-robin grant starting at r_rr, plus the pops it implies.
    always_comb begin
        w_gnt_any   = 1'b0;
        w_gnt_valid = 1'b0;
        w_gnt       = '0;
        w_drd       = '0;
        w_srd       = '0;
        w_sel_data  = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (!w_gnt_any && w_cand[(32'(r_rr) + i) % FLUX]) begin
                w_gnt_any = 1'b1;
                w_gnt     = FW'((32'(r_rr) + i) % FLUX);
            end
        end
        if (w_gnt_any) begin
            w_srd[w_gnt] = 1'b1;
            w_gnt_valid  = !w_bad[w_gnt];
            for (int unsigned p = 0; p < PORTS; p++) begin
                if (w_gnt_valid && (w_shead[w_gnt] == SELW'(p))) begin
                    w_drd[p*FLUX + 32'(w_gnt)] = 1'b1;
                    w_sel_data = r_dmem[p*FLUX + 32'(w_gnt)][r_drp[p*FLUX + 32'(w_gnt)]];
                end
            end
        end
        w_rr_next = FW'((32'(w_gnt) + 32'd1) % FLUX);
    end

    // Pointers, counts, arbitration pointer and output shadow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned q = 0; q < NQ; q++) begin
                r_dwp[q]  <= '0;
                r_drp[q]  <= '0;
                r_dcnt[q] <= '0;
            end
            for (int unsigned f = 0; f < FLUX; f++) begin
                r_swp[f]  <= '0;
                r_srp[f]  <= '0;
                r_scnt[f] <= '0;
            end
            r_rr        <= '0;
            r_last_data <= '0;
            r_last_flux <= '0;
        end else begin
            for (int unsigned q = 0; q < NQ; q++) begin
                if (w_dwr[q]) r_dwp[q] <= r_dwp[q] + AW'(1);
                if (w_drd[q]) r_drp[q] <= r_drp[q] + AW'(1);
                case ({w_dwr[q], w_drd[q]})
                    2'b10:   r_dcnt[q] <= r_dcnt[q] + (AW + 1)'(1);
                    2'b01:   r_dcnt[q] <= r_dcnt[q] - (AW + 1)'(1);
                    default: ;
                endcase
            end
            for (int unsigned f = 0; f < FLUX; f++) begin
                if (w_swr[f]) r_swp[f] <= r_swp[f] + AW'(1);
                if (w_srd[f]) r_srp[f] <= r_srp[f] + AW'(1);
                case ({w_swr[f], w_srd[f]})
                    2'b10:   r_scnt[f] <= r_scnt[f] + (AW + 1)'(1);
                    2'b01:   r_scnt[f] <= r_scnt[f] - (AW + 1)'(1);
                    default: ;
                endcase
            end
            if (w_gnt_any)
                r_rr <= w_rr_next;
            if (w_gnt_valid) begin
                r_last_data <= w_sel_data;
                r_last_flux <= w_gnt;
            end
        end
    end

    // FIFO storage; no reset needed, counts gate every read.
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < PORTS; p++)
            for (int unsigned f = 0; f < FLUX; f++)
                if (w_dwr[p*FLUX + f])
                    r_dmem[p*FLUX + f][r_dwp[p*FLUX + f]] <= in_data[p*WIDTH +: WIDTH];
        for (int unsigned f = 0; f < FLUX; f++)
            if (w_swr[f])
                r_smem[f][r_swp[f]] <= sel_data;
    end

`ifdef PICK_BADSEL_CNT_EN
    logic [7:0] r_badsel_cnt;

    // A granted non-valid selection is by construction a bad-selector pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_badsel_cnt <= '0;
        else if (w_gnt_any && !w_gnt_valid && (r_badsel_cnt != 8'hFF))
            r_badsel_cnt <= r_badsel_cnt + 8'd1;
    end

    assign badsel_cnt = r_badsel_cnt;
`endif

    assign in_full  = w_dfull;
    assign sel_full = w_sfull;
    assign out_wr   = w_gnt_valid;
    assign out_data = w_gnt_valid ? w_sel_data : r_last_data;
    assign out_flux = w_gnt_valid ? w_gnt      : r_last_flux;

endmodule
